// File: rtl/bus_arb_pkg.sv
// Shared definitions for the Zorro II DMA bus arbiter: state encoding,
// default timing parameters, counter width and the registered output bundle.
package bus_arb_pkg;

  localparam int unsigned CNT_W              = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned CPU_MIN_CYCLES_DEF = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_REQ  = 3'd1,
    ST_MB_GRANT = 3'd2,
    ST_DMA      = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_HOLDOFF  = 3'd5
  } arb_state_e;

  // Every arbiter output lives in one register bundle so that no input can
  // reach an output without passing through a flop.
  typedef struct packed {
    logic cpu_br_n;
    logic cpu_bgack_n;
    logic mb_bg_n;
    logic drive_en;
    logic dma_active;
    logic grant_timeout;
  } arb_out_t;

  localparam arb_out_t OUT_RESET = '{
    cpu_br_n:      1'b1,
    cpu_bgack_n:   1'b1,
    mb_bg_n:       1'b1,
    drive_en:      1'b1,
    dma_active:    1'b0,
    grant_timeout: 1'b0
  };

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus handshake bundle between the on-board CPU, the motherboard DMA master
// and the arbiter. The slave view belongs to the arbiter, the master view to
// the surrounding board logic.
interface bus_arbiter_if;

  logic MB_BR_n;
  logic MB_BGACK_n;
  logic AS_CPU_n;
  logic CPU_BG_n;

  logic CPU_BR_n;
  logic CPU_BGACK_n;
  logic MB_BG_n;
  logic MB_DRIVE_EN;
  logic DMA_ACTIVE;
  logic GRANT_TIMEOUT;

  // AS_MB_n / R/W / address buffer output enable, and the fastram/ATA strobe
  // source select (1 = decoders take strobes from the motherboard).
  logic AS_MB_OE;
  logic DEC_MB_STROBE;

  modport slave (
    input  MB_BR_n, MB_BGACK_n, AS_CPU_n, CPU_BG_n,
    output CPU_BR_n, CPU_BGACK_n, MB_BG_n, MB_DRIVE_EN, DMA_ACTIVE,
           GRANT_TIMEOUT, AS_MB_OE, DEC_MB_STROBE
  );

  modport master (
    output MB_BR_n, MB_BGACK_n, AS_CPU_n, CPU_BG_n,
    input  CPU_BR_n, CPU_BGACK_n, MB_BG_n, MB_DRIVE_EN, DMA_ACTIVE,
           GRANT_TIMEOUT, AS_MB_OE, DEC_MB_STROBE
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous reset to a selectable idle value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates bus ownership between the on-board CPU and a Zorro II DMA
// master: requests the bus from the CPU, grants it to the motherboard master,
// withdraws stale grants after a timeout and enforces a CPU hold-off window
// after every DMA tenure.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CPU_MIN_CYCLES = CPU_MIN_CYCLES_DEF
) (
  input  logic         C7M,
  input  logic         RESET,
  bus_arbiter_if.slave bus
);

  localparam logic [CNT_W:0] TMO_LIMIT = TIMEOUT_CYCLES[CNT_W:0];
  localparam cnt_t           HOLD_LOAD = CPU_MIN_CYCLES[CNT_W-1:0];
  localparam cnt_t           CNT_ONE   = cnt_t'(1);

  logic           w_br_raw;
  logic           w_bgack_raw;
  logic           w_sbr;
  logic           w_sbgack;
  logic [CNT_W:0] w_tmo_inc;

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_out_t   r_out;
  arb_out_t   w_out_nxt;
  cnt_t       r_tmo_cnt;
  cnt_t       w_tmo_cnt_nxt;
  cnt_t       r_hold_cnt;
  cnt_t       w_hold_cnt_nxt;

  sync2 #(.RST_VAL(1'b1)) u_sync_br (
    .i_clk (C7M),
    .i_rst (RESET),
    .i_d   (bus.MB_BR_n),
    .o_q   (w_br_raw)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_bgack (
    .i_clk (C7M),
    .i_rst (RESET),
    .i_d   (bus.MB_BGACK_n),
    .o_q   (w_bgack_raw)
  );

  assign w_sbr     = ~w_br_raw;
  assign w_sbgack  = ~w_bgack_raw;
  assign w_tmo_inc = {1'b0, r_tmo_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // State, counters and the output bundle advance together on C7M
  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_out      <= OUT_RESET;
      r_tmo_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next state and next registered outputs; outputs change only on transitions
  always_comb begin
    w_state_nxt    = r_state;
    w_out_nxt      = r_out;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_hold_cnt_nxt = r_hold_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_sbr && (r_hold_cnt == '0)) begin
          w_state_nxt        = ST_CPU_REQ;
          w_out_nxt.cpu_br_n = 1'b0;
        end
      end

      ST_CPU_REQ: begin
        if (!w_sbr) begin
          w_state_nxt           = ST_RELEASE;
          w_out_nxt.cpu_br_n    = 1'b1;
          w_out_nxt.cpu_bgack_n = 1'b1;
        end else if (!bus.CPU_BG_n && bus.AS_CPU_n) begin
          w_state_nxt        = ST_MB_GRANT;
          w_out_nxt.drive_en = 1'b0;
          w_out_nxt.mb_bg_n  = 1'b0;
          w_tmo_cnt_nxt      = '0;
        end
      end

      ST_MB_GRANT: begin
        if (w_sbgack) begin
          w_state_nxt           = ST_DMA;
          w_out_nxt.mb_bg_n     = 1'b1;
          w_out_nxt.dma_active  = 1'b1;
          w_out_nxt.cpu_bgack_n = 1'b0;
        end else if (!w_sbr) begin
          w_state_nxt           = ST_RELEASE;
          w_out_nxt.mb_bg_n     = 1'b1;
          w_out_nxt.cpu_br_n    = 1'b1;
          w_out_nxt.cpu_bgack_n = 1'b1;
        end else if (w_tmo_inc == TMO_LIMIT) begin
          // The grant has now been low for TIMEOUT_CYCLES full cycles.
          w_state_nxt             = ST_RELEASE;
          w_out_nxt.mb_bg_n       = 1'b1;
          w_out_nxt.cpu_br_n      = 1'b1;
          w_out_nxt.cpu_bgack_n   = 1'b1;
          w_out_nxt.grant_timeout = 1'b1;
          w_tmo_cnt_nxt           = '0;
        end else begin
          w_tmo_cnt_nxt = w_tmo_inc[CNT_W-1:0];
        end
      end

      ST_DMA: begin
        if (!w_sbgack) begin
          w_state_nxt           = ST_RELEASE;
          w_out_nxt.dma_active  = 1'b0;
          w_out_nxt.cpu_br_n    = 1'b1;
          w_out_nxt.cpu_bgack_n = 1'b1;
        end
      end

      ST_RELEASE: begin
        // Buffers come back one cycle after entry, after DMA_ACTIVE has dropped.
        w_out_nxt.drive_en = 1'b1;
        if (bus.CPU_BG_n) begin
          w_state_nxt    = ST_HOLDOFF;
          w_hold_cnt_nxt = HOLD_LOAD;
        end
      end

      ST_HOLDOFF: begin
        if (r_hold_cnt <= CNT_ONE) begin
          w_state_nxt    = ST_IDLE;
          w_hold_cnt_nxt = '0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.CPU_BR_n      = r_out.cpu_br_n;
  assign bus.CPU_BGACK_n   = r_out.cpu_bgack_n;
  assign bus.MB_BG_n       = r_out.mb_bg_n;
  assign bus.MB_DRIVE_EN   = r_out.drive_en;
  assign bus.DMA_ACTIVE    = r_out.dma_active;
  assign bus.GRANT_TIMEOUT = r_out.grant_timeout;
  assign bus.AS_MB_OE      = r_out.drive_en;
  assign bus.DEC_MB_STROBE = r_out.dma_active;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios (normal DMA, CPU busy, request
// withdrawn, grant timeout, rogue master, reset during DMA) with a phase-level
// ownership model compared against the DUT every cycle.
module tb_bus_arbiter;

  localparam int TMO  = 255;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;

  bus_arbiter_if u_if ();

  bus_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .CPU_MIN_CYCLES (HOLD)
  ) dut (
    .C7M   (clk),
    .RESET (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- ownership model ----------------
  // Phase of bus ownership as seen from the rules: who holds the bus and what
  // has been requested. Outputs are derived from the phase when compared.
  string      m_phase;
  string      m_nxt;
  logic [1:0] m_br_pipe;
  logic [1:0] m_ack_pipe;
  int         m_low;
  int         m_hold;
  int         m_rel_age;
  logic       e_drive;
  logic       e_tmo;
  logic       m_sbr;
  logic       m_sack;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase    = "idle";
        m_br_pipe  = 2'b00;
        m_ack_pipe = 2'b00;
        m_low      = 0;
        m_hold     = 0;
        m_rel_age  = 0;
        e_drive    = 1'b1;
        e_tmo      = 1'b0;
      end else begin
        m_sbr  = m_br_pipe[1];
        m_sack = m_ack_pipe[1];
        m_nxt  = m_phase;
        if (m_phase == "idle") begin
          if (m_sbr) m_nxt = "cpu_req";
        end else if (m_phase == "cpu_req") begin
          if (!m_sbr) m_nxt = "release";
          else if (!u_if.CPU_BG_n && u_if.AS_CPU_n) begin
            m_nxt = "grant";
            m_low = 0;
          end
        end else if (m_phase == "grant") begin
          m_low++;
          if (m_sack) m_nxt = "dma";
          else if (!m_sbr) m_nxt = "release";
          else if (m_low == TMO) begin
            m_nxt = "release";
            e_tmo = 1'b1;
          end
        end else if (m_phase == "dma") begin
          if (!m_sack) m_nxt = "release";
        end else if (m_phase == "release") begin
          if (u_if.CPU_BG_n) begin
            m_nxt  = "holdoff";
            m_hold = 0;
          end
        end else if (m_phase == "holdoff") begin
          m_hold++;
          if (m_hold == HOLD) m_nxt = "idle";
        end
        if (m_nxt == "release" && m_phase == "release") m_rel_age++;
        else m_rel_age = 0;
        if (m_nxt == "grant" || m_nxt == "dma") e_drive = 1'b0;
        else if (!(m_nxt == "release" && m_rel_age == 0)) e_drive = 1'b1;
        m_phase    = m_nxt;
        m_br_pipe  = {m_br_pipe[0], ~u_if.MB_BR_n};
        m_ack_pipe = {m_ack_pipe[0], ~u_if.MB_BGACK_n};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic x_busy;
  logic x_grant;
  logic x_dma;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        x_busy  = (m_phase == "cpu_req" || m_phase == "grant" || m_phase == "dma");
        x_grant = (m_phase == "grant");
        x_dma   = (m_phase == "dma");
        check("CPU_BR_n",      u_if.CPU_BR_n,      !x_busy);
        check("CPU_BGACK_n",   u_if.CPU_BGACK_n,   !x_dma);
        check("MB_BG_n",       u_if.MB_BG_n,       !x_grant);
        check("DMA_ACTIVE",    u_if.DMA_ACTIVE,    x_dma);
        check("MB_DRIVE_EN",   u_if.MB_DRIVE_EN,   e_drive);
        check("AS_MB_OE",      u_if.AS_MB_OE,      e_drive);
        check("DEC_MB_STROBE", u_if.DEC_MB_STROBE, x_dma);
        check("GRANT_TIMEOUT", u_if.GRANT_TIMEOUT, e_tmo);
        check("inv_bg_drive",  !(u_if.MB_BG_n === 1'b0 && u_if.MB_DRIVE_EN === 1'b1), 1);
        check("inv_dma",       !(u_if.DMA_ACTIVE === 1'b1 &&
                                 (u_if.MB_DRIVE_EN !== 1'b0 || u_if.CPU_BGACK_n !== 1'b0)), 1);
      end
    end
  end

  // ---------------- CPU responder ----------------
  // Grants the bus two cycles after CPU_BR_n falls, takes it back one cycle
  // after CPU_BR_n rises.
  int cpu_low_cnt;
  initial begin
    cpu_low_cnt   = 0;
    u_if.CPU_BG_n = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (u_if.CPU_BR_n === 1'b0) begin
        cpu_low_cnt++;
        if (cpu_low_cnt >= 2) u_if.CPU_BG_n = 1'b0;
      end else begin
        cpu_low_cnt   = 0;
        u_if.CPU_BG_n = 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return u_if.CPU_BR_n;
      1:       return u_if.MB_BG_n;
      2:       return u_if.DMA_ACTIVE;
      default: return u_if.MB_DRIVE_EN;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int limit, output int edges);
    edges = 0;
    while (sig(sel) !== val && edges < limit) begin
      step();
      edges++;
    end
    check(name, sig(sel), val);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_br_n"},    u_if.CPU_BR_n,      1);
    check({tag, "_cpu_bgack_n"}, u_if.CPU_BGACK_n,   1);
    check({tag, "_mb_bg_n"},     u_if.MB_BG_n,       1);
    check({tag, "_drive_en"},    u_if.MB_DRIVE_EN,   1);
    check({tag, "_dma_active"},  u_if.DMA_ACTIVE,    0);
    check({tag, "_timeout"},     u_if.GRANT_TIMEOUT, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t, required finish before 400000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  int e;
  int lowcnt;

  initial begin
    rst             = 1'b1;
    u_if.MB_BR_n    = 1'b1;
    u_if.MB_BGACK_n = 1'b1;
    u_if.AS_CPU_n   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    step();
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();

    // Normal DMA
    u_if.MB_BR_n = 1'b0;
    wait_sig("dma_cpu_br", 0, 1'b0, 10, e);
    check("br_latency", e, 3);
    wait_sig("dma_mb_bg", 1, 1'b0, 10, e);
    check("grant_after_cpu_bg", e, 2);
    repeat (5) step();
    u_if.MB_BGACK_n = 1'b0;
    wait_sig("dma_active_on", 2, 1'b1, 10, e);
    check("ack_latency", e, 3);
    check("dma_mb_bg_high", u_if.MB_BG_n, 1);
    repeat (17) step();
    u_if.MB_BGACK_n = 1'b1;
    u_if.MB_BR_n    = 1'b1;
    wait_sig("dma_active_off", 2, 1'b0, 10, e);
    check("release_latency", e, 3);
    check("release_cpu_br", u_if.CPU_BR_n, 1);
    wait_sig("drive_back", 3, 1'b1, 5, e);
    check("drive_en_delay", e, 1);
    repeat (8) step();

    // CPU busy: grant held off while AS_CPU_n is low
    u_if.AS_CPU_n = 1'b0;
    u_if.MB_BR_n  = 1'b0;
    wait_sig("busy_cpu_br", 0, 1'b0, 10, e);
    repeat (12) step();
    check("busy_no_grant", u_if.MB_BG_n, 1);
    u_if.AS_CPU_n = 1'b1;
    wait_sig("busy_grant", 1, 1'b0, 5, e);
    check("busy_grant_delay", e, 1);
    u_if.MB_BGACK_n = 1'b0;
    wait_sig("busy_dma", 2, 1'b1, 10, e);
    repeat (3) step();
    u_if.MB_BGACK_n = 1'b1;
    u_if.MB_BR_n    = 1'b1;
    repeat (12) step();

    // Request withdrawn while the CPU still owns the bus
    u_if.AS_CPU_n = 1'b0;
    u_if.MB_BR_n  = 1'b0;
    wait_sig("wd_cpu_br", 0, 1'b0, 10, e);
    repeat (4) step();
    u_if.MB_BR_n = 1'b1;
    lowcnt = 0;
    repeat (12) begin
      step();
      if (u_if.MB_BG_n === 1'b0) lowcnt++;
    end
    check("wd_no_bg_pulse", lowcnt, 0);
    check("wd_cpu_br_off", u_if.CPU_BR_n, 1);
    check("wd_no_timeout", u_if.GRANT_TIMEOUT, 0);
    u_if.AS_CPU_n = 1'b1;
    repeat (4) step();

    // Grant timeout: MB_BGACK_n never asserted
    u_if.MB_BR_n = 1'b0;
    wait_sig("tmo_grant", 1, 1'b0, 20, e);
    lowcnt = 1;
    while (u_if.MB_BG_n === 1'b0 && lowcnt < 400) begin
      step();
      if (u_if.MB_BG_n === 1'b0) lowcnt++;
    end
    check("tmo_grant_width", lowcnt, TMO);
    check("tmo_flag", u_if.GRANT_TIMEOUT, 1);
    check("tmo_cpu_br_off", u_if.CPU_BR_n, 1);
    wait_sig("tmo_rerequest", 0, 1'b0, 20, e);
    check("holdoff_gap", e, HOLD + 2);
    u_if.MB_BR_n = 1'b1;
    repeat (20) step();
    check("tmo_flag_sticky", u_if.GRANT_TIMEOUT, 1);

    // Rogue master: BR and BGACK together from idle, then reset mid-DMA
    u_if.MB_BR_n    = 1'b0;
    u_if.MB_BGACK_n = 1'b0;
    wait_sig("rogue_cpu_br", 0, 1'b0, 10, e);
    check("rogue_no_early_dma", u_if.DMA_ACTIVE, 0);
    wait_sig("rogue_dma", 2, 1'b1, 10, e);
    repeat (10) step();
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    u_if.MB_BR_n    = 1'b1;
    u_if.MB_BGACK_n = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    check("post_reset_idle_br", u_if.CPU_BR_n, 1);
    check("post_reset_idle_dma", u_if.DMA_ACTIVE, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
